// File: rtl/grf_multiport_if.sv
// Bus bundle for the multiport register file: read ports, dual write
// ports, scrub control and the registered write-trace outputs.
interface grf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [1:0]               we;
    logic [2*ADDR_W-1:0]      wa;
    logic [2*DATA_W-1:0]      wd;
    logic [31:0]              now_pc;
    logic                     clr_req;
    logic                     busy;
    logic [1:0]               trace_vld;
    logic [2*ADDR_W-1:0]      trace_addr;
    logic [2*DATA_W-1:0]      trace_data;
    logic [31:0]              trace_pc;

    // Datapath / requester side
    modport master (
        output rd_addr, we, wa, wd, now_pc, clr_req,
        input  rd_data, busy, trace_vld, trace_addr, trace_data, trace_pc
    );

    // Register file side
    modport slave (
        input  rd_addr, we, wa, wd, now_pc, clr_req,
        output rd_data, busy, trace_vld, trace_addr, trace_data, trace_pc
    );
endinterface

// File: rtl/grf_multiport.sv
// General register file with NUM_RD combinational read ports, two
// prioritised write ports, optional write-to-read bypass, a scrub FSM that
// clears the file one entry per cycle, and a registered write-trace bus.
// Entry 0 is hardwired to zero.
module grf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    grf_multiport_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [1:0]          trace_vld_q, trace_vld_d;
    logic [2*ADDR_W-1:0] trace_addr_q, trace_addr_d;
    logic [2*DATA_W-1:0] trace_data_q, trace_data_d;
    logic [31:0]         trace_pc_q, trace_pc_d;

    logic                    busy;
    logic                    commit0, commit1;
    logic [ADDR_W-1:0]       wa0, wa1;
    logic [DATA_W-1:0]       wd0, wd1;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;

    assign wa0  = bus.wa[0 +: ADDR_W];
    assign wa1  = bus.wa[ADDR_W +: ADDR_W];
    assign wd0  = bus.wd[0 +: DATA_W];
    assign wd1  = bus.wd[DATA_W +: DATA_W];
    assign busy = (state_q == CLEAR);

    // A write commits only when enabled, not targeting entry 0, and no scrub is running
    always_comb begin
        commit0 = bus.we[0] && (wa0 != '0) && !busy;
        commit1 = bus.we[1] && (wa1 != '0) && !busy;
    end

    // Scrub FSM: walk the pointer from entry 1 up to the last entry, then return to idle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = ADDR_W'(1);
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    // Next array contents: scrub clears one entry, otherwise port 1 is applied after port 0 so it wins a collision
    always_comb begin
        mem_d = mem_q;
        if (busy) begin
            mem_d[ptr_q] = '0;
        end else begin
            if (commit0) begin
                mem_d[wa0] = wd0;
            end
            if (commit1) begin
                mem_d[wa1] = wd1;
            end
        end
    end

    // Trace: one valid pulse per stored write; a port-0 write shadowed by port 1 leaves no trace
    always_comb begin
        trace_vld_d  = {commit1, commit0 && !(commit1 && (wa0 == wa1))};
        trace_addr_d = trace_addr_q;
        trace_data_d = trace_data_q;
        trace_pc_d   = trace_pc_q;
        if (trace_vld_d[0]) begin
            trace_addr_d[0 +: ADDR_W] = wa0;
            trace_data_d[0 +: DATA_W] = wd0;
        end
        if (trace_vld_d[1]) begin
            trace_addr_d[ADDR_W +: ADDR_W] = wa1;
            trace_data_d[DATA_W +: DATA_W] = wd1;
        end
        if (trace_vld_d != 2'b00) begin
            trace_pc_d = bus.now_pc;
        end
    end

    // Combinational reads, optionally forwarding this cycle's committing write (port 1 first)
    always_comb begin
        rd_data_c = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_c[k*DATA_W +: DATA_W] = mem_q[bus.rd_addr[k*ADDR_W +: ADDR_W]];
            if (BYPASS != 0 && !busy && bus.rd_addr[k*ADDR_W +: ADDR_W] != '0) begin
                if (commit1 && wa1 == bus.rd_addr[k*ADDR_W +: ADDR_W]) begin
                    rd_data_c[k*DATA_W +: DATA_W] = wd1;
                end else if (commit0 && wa0 == bus.rd_addr[k*ADDR_W +: ADDR_W]) begin
                    rd_data_c[k*DATA_W +: DATA_W] = wd0;
                end
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            trace_vld_q  <= '0;
            trace_addr_q <= '0;
            trace_data_q <= '0;
            trace_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            trace_vld_q  <= trace_vld_d;
            trace_addr_q <= trace_addr_d;
            trace_data_q <= trace_data_d;
            trace_pc_q   <= trace_pc_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.rd_data    = rd_data_c;
    assign bus.busy       = busy;
    assign bus.trace_vld  = trace_vld_q;
    assign bus.trace_addr = trace_addr_q;
    assign bus.trace_data = trace_data_q;
    assign bus.trace_pc   = trace_pc_q;
endmodule
